// File: rtl/cdb_arbiter_if.sv
// Requester/broadcast bundle for the common data bus arbiter.
//   req_valid   : requester i holds a completed result
//   req_reorder : ROB index of each requester's result
//   req_value   : result data of each requester
//   req_ack     : combinational grant back to each requester
//   cdb_valid   : registered broadcast valid per slot
//   cdb_reorder : registered ROB index per slot
//   cdb_value   : registered data per slot
// slave modport = arbiter side, master modport = functional-unit/bus side.
interface cdb_arbiter_if #(
  parameter int unsigned NUM_REQ   = 6,
  parameter int unsigned CDB_PORTS = 2,
  parameter int unsigned ROB_IDX_W = 4
);
  logic [NUM_REQ-1:0]                  req_valid;
  logic [NUM_REQ-1:0][ROB_IDX_W-1:0]   req_reorder;
  logic [NUM_REQ-1:0][31:0]            req_value;
  logic [NUM_REQ-1:0]                  req_ack;
  logic [CDB_PORTS-1:0]                cdb_valid;
  logic [CDB_PORTS-1:0][ROB_IDX_W-1:0] cdb_reorder;
  logic [CDB_PORTS-1:0][31:0]          cdb_value;

  modport slave (
    input  req_valid, req_reorder, req_value,
    output req_ack, cdb_valid, cdb_reorder, cdb_value
  );

  modport master (
    output req_valid, req_reorder, req_value,
    input  req_ack, cdb_valid, cdb_reorder, cdb_value
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Two-slot round-robin arbiter for the common data bus.
// Picks up to two valid requesters per cycle starting at a rotating priority
// pointer, acknowledges them combinationally and broadcasts their results one
// cycle later. Counts cycles with more than two simultaneous requests.
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset
//   flush        : pipeline flush, suppresses grants and clears broadcasts
//   bus          : requester inputs, req_ack, registered cdb outputs
//   conflict_cnt : saturating count of oversubscribed cycles
module cdb_arbiter #(
  parameter int unsigned NUM_REQ   = 6,
  parameter int unsigned CDB_PORTS = 2,
  parameter int unsigned ROB_IDX_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  cdb_arbiter_if.slave      bus,
  output logic [15:0]       conflict_cnt
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]                  ptr;
  logic [PTR_W-1:0]                  ptr_next;
  logic [CDB_PORTS-1:0][PTR_W-1:0]   win;
  logic [CDB_PORTS-1:0]              win_vld;
  logic [NUM_REQ-1:0]                ack;
  logic                              oversub;

  // Single circular sweep from ptr: the first valid requester takes slot 0,
  // the second takes slot 1, which is exactly "next valid after slot 0".
  always_comb begin
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    logic [PTR_W-1:0] last;
    win      = '0;
    win_vld  = '0;
    ack      = '0;
    ptr_next = ptr;
    sum      = '0;
    idx      = '0;
    last     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(NUM_REQ)) begin
        sum = sum - (PTR_W+1)'(NUM_REQ);
      end
      idx = sum[PTR_W-1:0];
      if (bus.req_valid[idx] && !win_vld[1]) begin
        if (!win_vld[0]) begin
          win[0]     = idx;
          win_vld[0] = 1'b1;
        end else begin
          win[1]     = idx;
          win_vld[1] = 1'b1;
        end
      end
    end
    if (rst || flush) begin
      win_vld = '0;
    end
    if (win_vld[0]) ack[win[0]] = 1'b1;
    if (win_vld[1]) ack[win[1]] = 1'b1;
    last = win_vld[1] ? win[1] : win[0];
    if (win_vld[0]) begin
      ptr_next = (last == PTR_W'(NUM_REQ - 1)) ? '0 : last + PTR_W'(1);
    end
  end

  assign bus.req_ack = ack;
  assign oversub     = ($countones(bus.req_valid) > 2);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr             <= '0;
      conflict_cnt    <= '0;
      bus.cdb_valid   <= '0;
      bus.cdb_reorder <= '0;
      bus.cdb_value   <= '0;
    end else begin
      ptr <= ptr_next;
      if (!flush && oversub && (conflict_cnt != '1)) begin
        conflict_cnt <= conflict_cnt + 16'd1;
      end
      // win_vld is already cleared under flush, so slots drop to zero.
      bus.cdb_valid[0]   <= win_vld[0];
      bus.cdb_reorder[0] <= win_vld[0] ? bus.req_reorder[win[0]] : '0;
      bus.cdb_value[0]   <= win_vld[0] ? bus.req_value[win[0]]   : '0;
      bus.cdb_valid[1]   <= win_vld[1];
      bus.cdb_reorder[1] <= win_vld[1] ? bus.req_reorder[win[1]] : '0;
      bus.cdb_value[1]   <= win_vld[1] ? bus.req_value[win[1]]   : '0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
  logic        clk;
  logic        rst;
  logic        flush;
  logic [15:0] conflict_cnt;
  int          checks;
  int          errors;

  cdb_arbiter_if #(.NUM_REQ(6), .CDB_PORTS(2), .ROB_IDX_W(4)) bus ();

  cdb_arbiter #(.NUM_REQ(6), .CDB_PORTS(2), .ROB_IDX_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .bus          (bus.slave),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cdb(input string tag, input logic [1:0] vld,
                         input logic [7:0] ro, input logic [63:0] val);
    chk({tag, "_valid"},   64'(bus.cdb_valid),   64'(vld));
    chk({tag, "_reorder"}, 64'(bus.cdb_reorder), 64'(ro));
    chk({tag, "_value"},   bus.cdb_value,        val);
  endtask

  task automatic set_defaults;
    bus.req_reorder = {4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9};
    bus.req_value   = {32'hA5, 32'hA4, 32'hA3, 32'hA2, 32'hA1, 32'hA0};
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    flush  = 1'b0;
    bus.req_valid = 6'b111111;
    set_defaults();

    // Reset with requests present
    tick();
    chk("rst_ack", 64'(bus.req_ack), 64'h0);
    tick();
    chk("rst_ack2", 64'(bus.req_ack), 64'h0);
    chk_cdb("rst_cdb", 2'b00, 8'h00, 64'h0);
    chk("rst_cnt", 64'(conflict_cnt), 64'h0);
    chk("rst_ptr", 64'(dut.ptr), 64'h0);

    // Two grants, slot order preserved
    rst = 1'b0;
    bus.req_valid      = 6'b000101;
    bus.req_reorder[0] = 4'd3;
    bus.req_reorder[2] = 4'd7;
    bus.req_value[0]   = 32'h11;
    bus.req_value[2]   = 32'h22;
    #1;
    chk("two_ack", 64'(bus.req_ack), 64'h05);
    tick();
    bus.req_valid = 6'b000000;
    chk_cdb("two_cdb", 2'b11, {4'd7, 4'd3}, {32'h22, 32'h11});
    chk("two_ptr", 64'(dut.ptr), 64'h3);
    chk("two_cnt", 64'(conflict_cnt), 64'h0);

    // Idle cycle: slots invalid and zero, ptr held
    tick();
    chk_cdb("idle_cdb", 2'b00, 8'h00, 64'h0);
    chk("idle_ptr", 64'(dut.ptr), 64'h3);

    // Single grant with wrap in the search (ptr 3 -> requester 1)
    set_defaults();
    bus.req_valid = 6'b000010;
    #1;
    chk("one_ack", 64'(bus.req_ack), 64'h02);
    tick();
    chk_cdb("one_cdb", 2'b01, {4'd0, 4'd10}, {32'h0, 32'hA1});
    chk("one_ptr", 64'(dut.ptr), 64'h2);

    // Winner at NUM_REQ-1 wraps ptr to 0
    bus.req_valid = 6'b100000;
    #1;
    chk("wrap_ack", 64'(bus.req_ack), 64'h20);
    tick();
    chk("wrap_ptr", 64'(dut.ptr), 64'h0);

    // All six valid, granted requesters drop their request
    bus.req_valid = 6'b111111;
    #1;
    chk("rr1_ack", 64'(bus.req_ack), 64'h03);
    tick();
    chk_cdb("rr1_cdb", 2'b11, {4'd10, 4'd9}, {32'hA1, 32'hA0});
    chk("rr1_cnt", 64'(conflict_cnt), 64'd1);
    bus.req_valid = 6'b111100;
    #1;
    chk("rr2_ack", 64'(bus.req_ack), 64'h0C);
    tick();
    chk_cdb("rr2_cdb", 2'b11, {4'd12, 4'd11}, {32'hA3, 32'hA2});
    chk("rr2_cnt", 64'(conflict_cnt), 64'd2);
    bus.req_valid = 6'b110000;
    #1;
    chk("rr3_ack", 64'(bus.req_ack), 64'h30);
    tick();
    chk_cdb("rr3_cdb", 2'b11, {4'd14, 4'd13}, {32'hA5, 32'hA4});
    chk("rr3_cnt", 64'(conflict_cnt), 64'd2);
    chk("rr3_ptr", 64'(dut.ptr), 64'h0);
    bus.req_valid = 6'b000011;
    #1;
    chk("rr4_ack", 64'(bus.req_ack), 64'h03);
    tick();
    chk_cdb("rr4_cdb", 2'b11, {4'd10, 4'd9}, {32'hA1, 32'hA0});
    chk("rr4_cnt", 64'(conflict_cnt), 64'd2);
    chk("rr4_ptr", 64'(dut.ptr), 64'h2);

    // Move ptr to 5, then slot0=5, slot1=0
    bus.req_valid = 6'b010000;
    tick();
    chk("p5_ptr", 64'(dut.ptr), 64'h5);
    bus.req_valid = 6'b100001;
    #1;
    chk("p5_ack", 64'(bus.req_ack), 64'h21);
    tick();
    chk_cdb("p5_cdb", 2'b11, {4'd9, 4'd14}, {32'hA0, 32'hA5});
    chk("p5_ptr_new", 64'(dut.ptr), 64'h1);

    // Grant at N, flush at N+1
    bus.req_valid = 6'b000100;
    #1;
    chk("fl_n_ack", 64'(bus.req_ack), 64'h04);
    tick();
    flush = 1'b1;
    bus.req_valid = 6'b111111;
    #1;
    chk("fl_ack", 64'(bus.req_ack), 64'h0);
    chk_cdb("fl_n1_cdb", 2'b01, {4'd0, 4'd11}, {32'h0, 32'hA2});
    tick();
    flush = 1'b0;
    bus.req_valid = 6'b000000;
    chk_cdb("fl_n2_cdb", 2'b00, 8'h00, 64'h0);
    chk("fl_ptr", 64'(dut.ptr), 64'h3);
    chk("fl_cnt", 64'(conflict_cnt), 64'd2);

    // Reset mid-operation discards the pending broadcast
    bus.req_valid = 6'b001111;
    #1;
    chk("mid_ack", 64'(bus.req_ack), 64'h09);
    tick();
    chk_cdb("mid_cdb", 2'b11, {4'd9, 4'd12}, {32'hA0, 32'hA3});
    chk("mid_cnt", 64'(conflict_cnt), 64'd3);
    rst = 1'b1;
    #1;
    chk("mrst_ack", 64'(bus.req_ack), 64'h0);
    tick();
    chk_cdb("mrst_cdb", 2'b00, 8'h00, 64'h0);
    chk("mrst_ptr", 64'(dut.ptr), 64'h0);
    chk("mrst_cnt", 64'(conflict_cnt), 64'h0);

    // Saturation: three valid requests every cycle
    rst = 1'b0;
    bus.req_valid = 6'b000111;
    repeat (65534) tick();
    chk("sat_fffe", 64'(conflict_cnt), 64'hFFFE);
    tick();
    chk("sat_ffff", 64'(conflict_cnt), 64'hFFFF);
    tick();
    tick();
    chk("sat_hold", 64'(conflict_cnt), 64'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
